// File: rtl/ring_decoder_if.sv
// rtl/ring_decoder_if.sv - ring state sample bus and decoded status outputs
interface ring_decoder_if #(
    parameter int N    = 4,
    parameter int IDXW = 2,
    parameter int REVW = 8
);
    logic [N-1:0]    ring_in;
    logic            ring_vld;
    logic            clr_err;
    logic [IDXW-1:0] idx;
    logic            idx_vld;
    logic            onehot_err;
    logic            seq_err;
    logic            err_sticky;
    logic            locked;
    logic [REVW-1:0] rev_cnt;

    // Side that presents ring samples and consumes decoded status
    modport master (
        output ring_in, ring_vld, clr_err,
        input  idx, idx_vld, onehot_err, seq_err, err_sticky, locked, rev_cnt
    );

    // Decoder side
    modport slave (
        input  ring_in, ring_vld, clr_err,
        output idx, idx_vld, onehot_err, seq_err, err_sticky, locked, rev_cnt
    );
endinterface

// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - one-hot ring counter decoder with sequence tracking and revolution count
module ring_decoder #(
    parameter int N        = 4,
    parameter int IDXW     = 2,
    parameter int REVW     = 8,
    parameter int DIR      = 0,
    parameter int LOCK_CNT = 2,
    parameter int HOLD_OK  = 0
) (
    input  logic          clk,
    input  logic          rst,
    ring_decoder_if.slave bus
);
    typedef enum logic {ACQUIRE, TRACK} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    prev_q, prev_d;
    logic            prev_vld_q, prev_vld_d;
    logic [3:0]      lock_q, lock_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            idx_vld_q, idx_vld_d;
    logic            onehot_err_q, onehot_err_d;
    logic            seq_err_q, seq_err_d;
    logic            err_sticky_q, err_sticky_d;
    logic [REVW-1:0] rev_q, rev_d;

    logic            legal;
    logic [N-1:0]    rot;
    logic            is_next;
    logic            is_hold;
    logic            expected;
    logic            wrap;
    logic [IDXW-1:0] enc;
    logic [3:0]      lock_inc;
    logic            lock_hit;

    // A legal sample has exactly one bit set: nonzero and clearing the lowest set bit leaves zero
    assign legal = (bus.ring_in != '0) && ((bus.ring_in & (bus.ring_in - N'(1))) == '0);

    // Where the hot bit should move next from the previous sample
    assign rot = (DIR == 0) ? {prev_q[0], prev_q[N-1:1]} : {prev_q[N-2:0], prev_q[N-1]};

    assign is_next  = (bus.ring_in == rot);
    assign is_hold  = (HOLD_OK != 0) && (bus.ring_in == prev_q);
    assign expected = prev_vld_q && (is_next || is_hold);
    // A rotation out of the wrapping end bit completes one revolution; holds never match rot
    assign wrap     = is_next && ((DIR == 0) ? prev_q[0] : prev_q[N-1]);
    assign lock_inc = lock_q + 4'd1;
    assign lock_hit = (lock_inc == 4'(LOCK_CNT));

    // Binary encoding of the hot bit; only used when the sample is legal
    always_comb begin
        enc = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.ring_in[i]) begin
                enc = enc | IDXW'(i);
            end
        end
    end

    // Next-state: acquire/track FSM, previous sample, lock counter and output pulses
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_vld_d   = prev_vld_q;
        lock_d       = lock_q;
        idx_d        = idx_q;
        idx_vld_d    = 1'b0;
        onehot_err_d = 1'b0;
        seq_err_d    = 1'b0;
        rev_d        = rev_q;

        if (bus.ring_vld) begin
            if (!legal) begin
                onehot_err_d = 1'b1;
                if (state_q == TRACK) begin
                    state_d    = ACQUIRE;
                    lock_d     = '0;
                    prev_d     = '0;
                    prev_vld_d = 1'b0;
                end
            end else begin
                idx_d      = enc;
                idx_vld_d  = 1'b1;
                prev_d     = bus.ring_in;
                prev_vld_d = 1'b1;
                if (state_q == ACQUIRE) begin
                    if (expected) begin
                        lock_d = lock_inc;
                        if (lock_hit) begin
                            state_d = TRACK;
                            lock_d  = '0;
                            rev_d   = '0;
                        end
                    end else begin
                        // First sample after reset or loss of lock only seeds prev
                        lock_d = '0;
                    end
                end else begin
                    if (expected) begin
                        if (wrap) begin
                            rev_d = rev_q + REVW'(1);
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = ACQUIRE;
                        lock_d    = '0;
                    end
                end
            end
        end

        // A fresh error outranks a clear on the same edge
        err_sticky_d = (err_sticky_q & ~bus.clr_err) | onehot_err_d | seq_err_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ACQUIRE;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            lock_q       <= '0;
            idx_q        <= '0;
            idx_vld_q    <= 1'b0;
            onehot_err_q <= 1'b0;
            seq_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            rev_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_vld_q   <= prev_vld_d;
            lock_q       <= lock_d;
            idx_q        <= idx_d;
            idx_vld_q    <= idx_vld_d;
            onehot_err_q <= onehot_err_d;
            seq_err_q    <= seq_err_d;
            err_sticky_q <= err_sticky_d;
            rev_q        <= rev_d;
        end
    end

    assign bus.idx        = idx_q;
    assign bus.idx_vld    = idx_vld_q;
    assign bus.onehot_err = onehot_err_q;
    assign bus.seq_err    = seq_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.locked     = (state_q == TRACK);
    assign bus.rev_cnt    = rev_q;
endmodule

// File: tb/tb_ring_decoder.sv
// tb/tb_ring_decoder.sv - scoreboard bench for ring_decoder (strict and hold-tolerant variants)
module tb_ring_decoder;
    typedef struct packed {
        logic [1:0] idx;
        logic       vld;
        logic       oh;
        logic       seq;
        logic       st;
        logic       lk;
        logic [7:0] rev;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    int   n0 = 0;
    int   n1 = 0;

    always #5 clk = ~clk;

    ring_decoder_if #(.N(4), .IDXW(2), .REVW(2)) if0 ();
    ring_decoder_if #(.N(4), .IDXW(2), .REVW(8)) if1 ();

    ring_decoder #(.N(4), .IDXW(2), .REVW(2), .DIR(0), .LOCK_CNT(2), .HOLD_OK(0)) dut0 (
        .clk (clk),
        .rst (rst_n),
        .bus (if0)
    );

    ring_decoder #(.N(4), .IDXW(2), .REVW(8), .DIR(0), .LOCK_CNT(2), .HOLD_OK(1)) dut1 (
        .clk (clk),
        .rst (rst_n),
        .bus (if1)
    );

    function automatic string fmt(input exp_t x);
        return $sformatf("idx=%0d vld=%0d oh=%0d seq=%0d sticky=%0d locked=%0d rev=%0d",
                         x.idx, x.vld, x.oh, x.seq, x.st, x.lk, x.rev);
    endfunction

    function automatic exp_t act0();
        return '{idx: if0.idx, vld: if0.idx_vld, oh: if0.onehot_err, seq: if0.seq_err,
                 st: if0.err_sticky, lk: if0.locked, rev: {6'b0, if0.rev_cnt}};
    endfunction

    function automatic exp_t act1();
        return '{idx: if1.idx, vld: if1.idx_vld, oh: if1.onehot_err, seq: if1.seq_err,
                 st: if1.err_sticky, lk: if1.locked, rev: if1.rev_cnt};
    endfunction

    function automatic exp_t mk(input logic [1:0] idx, input logic vld, input logic oh,
                                input logic seq, input logic st, input logic lk, input int rev);
        return '{idx: idx, vld: vld, oh: oh, seq: seq, st: st, lk: lk, rev: rev[7:0]};
    endfunction

    // Monitor for dut0: every sample yields idx_vld or onehot_err, so that marks a response
    initial begin
        exp_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (if0.idx_vld || if0.onehot_err)) begin
                a = act0();
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL dut0_unexpected_output: got %s, required no output", fmt(a));
                end else begin
                    e = q0.pop_front();
                    n0++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL dut0_sample_%0d: got %s, required %s", n0, fmt(a), fmt(e));
                    end
                end
            end
        end
    end

    // Monitor for dut1
    initial begin
        exp_t a, e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (if1.idx_vld || if1.onehot_err)) begin
                a = act1();
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL dut1_unexpected_output: got %s, required no output", fmt(a));
                end else begin
                    e = q1.pop_front();
                    n1++;
                    if (a !== e) begin
                        errors++;
                        $display("FAIL dut1_sample_%0d: got %s, required %s", n1, fmt(a), fmt(e));
                    end
                end
            end
        end
    end

    task automatic send0(input logic [3:0] r, input logic clr, input exp_t e);
        @(negedge clk);
        if0.ring_in  = r;
        if0.ring_vld = 1'b1;
        if0.clr_err  = clr;
        q0.push_back(e);
        @(posedge clk);
        #2;
        if0.ring_vld = 1'b0;
        if0.clr_err  = 1'b0;
    endtask

    task automatic send1(input logic [3:0] r, input exp_t e);
        @(negedge clk);
        if1.ring_in  = r;
        if1.ring_vld = 1'b1;
        q1.push_back(e);
        @(posedge clk);
        #2;
        if1.ring_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string name, input exp_t a);
        checks++;
        if (a !== '0) begin
            errors++;
            $display("FAIL %s: got %s, required all zero", name, fmt(a));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        if0.ring_in = '0; if0.ring_vld = 1'b0; if0.clr_err = 1'b0;
        if1.ring_in = '0; if1.ring_vld = 1'b0; if1.clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("dut0_reset_state", act0());
        check_zero("dut1_reset_state", act1());
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Rotation: lock on third sample, first revolution on fifth
        send0(4'b1000, 1'b0, mk(3, 1, 0, 0, 0, 0, 0));
        send0(4'b0100, 1'b0, mk(2, 1, 0, 0, 0, 0, 0));
        send0(4'b0010, 1'b0, mk(1, 1, 0, 0, 0, 1, 0));
        send0(4'b0001, 1'b0, mk(0, 1, 0, 0, 0, 1, 0));
        send0(4'b1000, 1'b0, mk(3, 1, 0, 0, 0, 1, 1));
        idle(3);

        // Illegal sample drops lock, idx and rev_cnt hold, then relock clears rev_cnt
        send0(4'b0110, 1'b0, mk(3, 0, 1, 0, 1, 0, 1));
        send0(4'b0100, 1'b0, mk(2, 1, 0, 0, 1, 0, 1));
        send0(4'b0010, 1'b0, mk(1, 1, 0, 0, 1, 0, 1));
        send0(4'b0001, 1'b0, mk(0, 1, 0, 0, 1, 1, 0));
        idle(2);
        send0(4'b1000, 1'b1, mk(3, 1, 0, 0, 0, 1, 1));

        // Skip from idx 2 to idx 0
        send0(4'b0100, 1'b0, mk(2, 1, 0, 0, 0, 1, 1));
        send0(4'b0001, 1'b0, mk(0, 1, 0, 1, 1, 0, 1));
        send0(4'b1000, 1'b0, mk(3, 1, 0, 0, 1, 0, 1));
        send0(4'b0100, 1'b0, mk(2, 1, 0, 0, 1, 1, 0));

        // Repeat is a sequence error when holds are not allowed
        send0(4'b0100, 1'b0, mk(2, 1, 0, 1, 1, 0, 0));
        send0(4'b0010, 1'b1, mk(1, 1, 0, 0, 0, 0, 0));
        send0(4'b0001, 1'b0, mk(0, 1, 0, 0, 0, 1, 0));

        // Four revolutions on a 2-bit counter: 1,2,3,0
        for (int r = 1; r <= 4; r++) begin
            send0(4'b1000, 1'b0, mk(3, 1, 0, 0, 0, 1, r % 4));
            send0(4'b0100, 1'b0, mk(2, 1, 0, 0, 0, 1, r % 4));
            send0(4'b0010, 1'b0, mk(1, 1, 0, 0, 0, 1, r % 4));
            send0(4'b0001, 1'b0, mk(0, 1, 0, 0, 0, 1, r % 4));
        end

        // clr_err on the same edge as a seq_err: set wins
        send0(4'b0010, 1'b1, mk(1, 1, 0, 1, 1, 0, 0));
        send0(4'b0001, 1'b0, mk(0, 1, 0, 0, 1, 0, 0));
        send0(4'b1000, 1'b0, mk(3, 1, 0, 0, 1, 1, 0));
        send0(4'b0100, 1'b0, mk(2, 1, 0, 0, 1, 1, 0));

        // Asynchronous reset between edges clears everything immediately
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("dut0_async_reset", act0());
        @(negedge clk);
        rst_n = 1'b1;
        send0(4'b0010, 1'b0, mk(1, 1, 0, 0, 0, 0, 0));
        send0(4'b0001, 1'b0, mk(0, 1, 0, 0, 0, 0, 0));
        send0(4'b1000, 1'b0, mk(3, 1, 0, 0, 0, 1, 0));
        idle(2);

        // Hold-tolerant variant: repeats count toward lock and never advance rev_cnt
        send1(4'b1000, mk(3, 1, 0, 0, 0, 0, 0));
        send1(4'b1000, mk(3, 1, 0, 0, 0, 0, 0));
        send1(4'b0100, mk(2, 1, 0, 0, 0, 1, 0));
        send1(4'b0100, mk(2, 1, 0, 0, 0, 1, 0));
        send1(4'b0010, mk(1, 1, 0, 0, 0, 1, 0));
        send1(4'b0001, mk(0, 1, 0, 0, 0, 1, 0));
        send1(4'b0001, mk(0, 1, 0, 0, 0, 1, 0));
        send1(4'b1000, mk(3, 1, 0, 0, 0, 1, 1));
        send1(4'b1000, mk(3, 1, 0, 0, 0, 1, 1));
        send1(4'b0001, mk(0, 1, 0, 1, 1, 0, 1));
        idle(4);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d/%0d outstanding, required 0/0",
                     q0.size(), q1.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
